mxu_sequencer: RTL

- Command-driven controller that runs one GRID_SIZE x GRID_SIZE signed matrix multiply C = A x B on the systolic mxu.
- Flow: accept command (A, B, C base addresses) -> read both tiles from the shared scratchpad -> clear the MXU -> drive skewed north/west feeds with ce -> write C back row-major -> pulse done.
- Replaces ad-hoc stage counting in the top-level instruction loop with a reusable handshake-driven block.

---
 rtl/accel_pkg.sv | 31 +++
 rtl/mxu_skew_feeder.sv | 48 ++++
 rtl/mxu_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_pkg
//  Description : Shared definitions for the matrix-multiply accelerator:
//                default sizing parameters, the sequencer state encoding and
//                a helper giving the length of the skewed feed phase.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

    localparam int NUM_SIZE_DEF  = 16;   // element width, signed
    localparam int GRID_SIZE_DEF = 2;    // systolic array dimension G
    localparam int ADDR_W_DEF    = 5;    // scratchpad word-address width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        FEED  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    // A skewed G x G feed needs G steps for the data plus G-1 steps of skew
    // on each of the two axes before the far-corner PE sees its last pair.
    function automatic int feed_len(input int g);
        return 3 * g - 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mxu_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_skew_feeder
//  Description : Combinational skew generator for the systolic MXU. Given the
//                buffered A and B tiles (row-major, element k = r*G+c in slice
//                [k*NUM_SIZE +: NUM_SIZE]) and the feed step t, drives
//                  west row i    = A[i][t-i]  when 0 <= t-i < G, else 0
//                  north col j   = B[t-j][j]  when 0 <= t-j < G, else 0
//                Both buses are forced to 0 when feed_en_i is low.
//  Ports       : feed_en_i  - feed phase active
//                step_i     - feed step t
//                a_tile_i   - packed A tile
//                b_tile_i   - packed B tile
//                north_o    - column j in [j*NUM_SIZE +: NUM_SIZE]
//                west_o     - row i in [i*NUM_SIZE +: NUM_SIZE]
//  Revision    : 1.0 - initial release
// ============================================================================
module mxu_skew_feeder #(
    parameter int NUM_SIZE  = 16,
    parameter int GRID_SIZE = 2,
    parameter int STEP_W    = 4
) (
    input  logic                                   feed_en_i,
    input  logic [STEP_W-1:0]                      step_i,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] a_tile_i,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] b_tile_i,
    output logic [NUM_SIZE*GRID_SIZE-1:0]          north_o,
    output logic [NUM_SIZE*GRID_SIZE-1:0]          west_o
);

    always_comb begin
        north_o = '0;
        west_o  = '0;
        if (feed_en_i) begin
            // Lane l carries element k of its row/column exactly when t == l + k.
            for (int l = 0; l < GRID_SIZE; l++) begin
                for (int k = 0; k < GRID_SIZE; k++) begin
                    if (int'(step_i) == l + k) begin
                        west_o[l*NUM_SIZE +: NUM_SIZE]  = a_tile_i[(l*GRID_SIZE + k)*NUM_SIZE +: NUM_SIZE];
                        north_o[l*NUM_SIZE +: NUM_SIZE] = b_tile_i[(k*GRID_SIZE + l)*NUM_SIZE +: NUM_SIZE];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mxu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mxu_sequencer
//  Description : Command-driven controller running one G x G signed matrix
//                multiply C = A x B on the systolic MXU. Sequence:
//                IDLE -> LOAD (read A and B tiles) -> CLEAR -> FEED (skewed
//                operands, ce high) -> WRITE (C row-major) -> DONE -> IDLE.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                cmd_valid/cmd_ready       - command handshake
//                cmd_a/b/c_addr            - tile base addresses
//                busy, done                - status, one-cycle done pulse
//                mem_rd_en/addr/data       - scratchpad read, 1-cycle latency
//                mem_wr_en/addr/data       - scratchpad write
//                mxu_ce, mxu_clear         - MXU control
//                mxu_north, mxu_west       - skewed operand buses
//                mxu_result                - PE(i,j) in slice i*G+j
//  Options     : MXU_SEQ_RELU_EN - clamp negative write-back words to 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mxu_sequencer
    import accel_pkg::*;
#(
    parameter int NUM_SIZE  = NUM_SIZE_DEF,
    parameter int GRID_SIZE = GRID_SIZE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [ADDR_W-1:0]                      cmd_a_addr,
    input  logic [ADDR_W-1:0]                      cmd_b_addr,
    input  logic [ADDR_W-1:0]                      cmd_c_addr,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   mem_rd_en,
    output logic [ADDR_W-1:0]                      mem_rd_addr,
    input  logic [NUM_SIZE-1:0]                    mem_rd_data,
    output logic                                   mem_wr_en,
    output logic [ADDR_W-1:0]                      mem_wr_addr,
    output logic [NUM_SIZE-1:0]                    mem_wr_data,
    output logic                                   mxu_ce,
    output logic                                   mxu_clear,
    output logic [NUM_SIZE*GRID_SIZE-1:0]          mxu_north,
    output logic [NUM_SIZE*GRID_SIZE-1:0]          mxu_west,
    input  logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] mxu_result
);

    localparam int GG       = GRID_SIZE * GRID_SIZE;
    localparam int LOAD_LEN = 2 * GG + 1;          // 2*G*G issues + 1 capture-only cycle
    localparam int FEED_LEN = feed_len(GRID_SIZE);
    localparam int CW       = $clog2(LOAD_LEN);    // LOAD is the longest phase
    localparam int TW       = NUM_SIZE * GG;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   a_base_q, a_base_d;
    logic [ADDR_W-1:0]   b_base_q, b_base_d;
    logic [ADDR_W-1:0]   c_base_q, c_base_d;
    logic [TW-1:0]       a_tile_q, a_tile_d;
    logic [TW-1:0]       b_tile_q, b_tile_d;

    logic [CW-1:0]       cap_idx;
    logic [CW-1:0]       wr_idx;
    logic [NUM_SIZE-1:0] wr_word;
    logic                feed_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            a_tile_q <= '0;
            b_tile_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            a_tile_q <= a_tile_d;
            b_tile_q <= b_tile_d;
        end
    end

    // Write-back word selection; the index is clamped so the select stays in
    // range in phases where the counter runs past G*G.
    always_comb begin
        wr_idx  = (cnt_q < CW'(GG)) ? cnt_q : '0;
        wr_word = mxu_result[int'(wr_idx)*NUM_SIZE +: NUM_SIZE];
`ifdef MXU_SEQ_RELU_EN
        if (wr_word[NUM_SIZE-1]) begin
            wr_word = '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_base_d    = a_base_q;
        b_base_d    = b_base_q;
        c_base_d    = c_base_q;
        a_tile_d    = a_tile_q;
        b_tile_d    = b_tile_q;
        cap_idx     = cnt_q - CW'(1);
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mxu_ce      = 1'b0;
        mxu_clear   = 1'b0;
        feed_en     = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    a_base_d = cmd_a_addr;
                    b_base_d = cmd_b_addr;
                    c_base_d = cmd_c_addr;
                end
            end

            LOAD: begin
                // Issue side: first G*G reads fetch A, next G*G fetch B.
                if (cnt_q < CW'(2*GG)) begin
                    mem_rd_en = 1'b1;
                    if (cnt_q < CW'(GG)) begin
                        mem_rd_addr = a_base_q + ADDR_W'(cnt_q);
                    end else begin
                        mem_rd_addr = b_base_q + ADDR_W'(cnt_q - CW'(GG));
                    end
                end
                // Capture side lags the issue by one cycle.
                if (cnt_q != '0) begin
                    if (cap_idx < CW'(GG)) begin
                        a_tile_d[int'(cap_idx)*NUM_SIZE +: NUM_SIZE] = mem_rd_data;
                    end else begin
                        b_tile_d[int'(cap_idx - CW'(GG))*NUM_SIZE +: NUM_SIZE] = mem_rd_data;
                    end
                end
                if (cnt_q == CW'(LOAD_LEN-1)) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            CLEAR: begin
                mxu_clear = 1'b1;
                state_d   = FEED;
                cnt_d     = '0;
            end

            FEED: begin
                mxu_ce  = 1'b1;
                feed_en = 1'b1;
                if (cnt_q == CW'(FEED_LEN-1)) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = c_base_q + ADDR_W'(cnt_q);
                mem_wr_data = wr_word;
                if (cnt_q == CW'(GG-1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    mxu_skew_feeder #(
        .NUM_SIZE  (NUM_SIZE),
        .GRID_SIZE (GRID_SIZE),
        .STEP_W    (CW)
    ) u_feeder (
        .feed_en_i (feed_en),
        .step_i    (cnt_q),
        .a_tile_i  (a_tile_q),
        .b_tile_i  (b_tile_q),
        .north_o   (mxu_north),
        .west_o    (mxu_west)
    );

endmodule
`default_nettype wire
